// File: rtl/kfpga_config_pkg.sv
// kfpga_config_pkg
//   Shared definitions for the tile configuration loader:
//   - TILE_CHAIN_LENGTH : config bits held by one tile's chain
//   - state_t           : loader FSM states
//   - calc_words / calc_last_bits : how a chain of a given length maps
//     onto bitstream words (word count, used bits in the final word)
package kfpga_config_pkg;

    localparam int TILE_CHAIN_LENGTH = 146;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bitstream words needed to cover the whole chain.
    function automatic int calc_words(input int chain_length, input int word_width);
        return (chain_length + word_width - 1) / word_width;
    endfunction

    // Bits of the final word that are actually shifted (taken from its MSB end).
    function automatic int calc_last_bits(input int chain_length, input int word_width);
        return chain_length - (calc_words(chain_length, word_width) - 1) * word_width;
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// config_loader_if
//   Bitstream word stream into the configuration loader.
//   Ports / signals:
//   - word_data  : bitstream word, MSB is the first bit shifted
//   - word_valid : source has a word on word_data
//   - word_ready : loader can take a word this cycle
//   Handshake: a word transfers on every rising clock edge where
//   word_valid and word_ready are both high. The source may raise or drop
//   word_valid at any time; word_ready never depends on word_valid.
interface config_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_serializer.sv
// config_serializer
//   Word buffer that accepts bitstream words and shifts them out MSB first.
//   Ports:
//   - clock, reset  : config clock, async active-high reset
//   - clear         : empty the buffer and restart the word count
//   - load_en       : loader is in LOAD; enables shifting and acceptance
//   - word_if       : word stream (slave side)
//   - shift_valid   : buffer holds at least one unsent bit
//   - shift_bit     : current MSB (0 when empty)
module config_serializer
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = TILE_CHAIN_LENGTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_en,
    config_loader_if.slave   word_if,
    output logic             shift_valid,
    output logic             shift_bit
);

    localparam int WORDS     = calc_words(CHAIN_LENGTH, WORD_WIDTH);
    localparam int LAST_BITS = calc_last_bits(CHAIN_LENGTH, WORD_WIDTH);
    localparam int CNT_W     = $clog2(WORD_WIDTH + 1);
    localparam int WCNT_W    = $clog2(WORDS + 1);

    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WCNT_W-1:0]     words_q, words_d;
    logic                  empty;
    logic                  last_bit;
    logic                  ready;
    logic                  fire;
    logic                  is_last_word;

    assign empty        = (cnt_q == '0);
    assign last_bit     = (cnt_q == CNT_W'(1));
    assign is_last_word = (words_q == WCNT_W'(WORDS - 1));

    // Ready while the buffer is draining its final bit lets the next word
    // land on the same edge, so back-to-back words shift with no gap.
    always_comb begin
        ready = load_en && (empty || last_bit) && (words_q < WCNT_W'(WORDS));
    end

    assign word_if.word_ready = ready;
    assign fire               = ready && word_if.word_valid;
    assign shift_valid        = !empty;
    assign shift_bit          = !empty && shreg_q[WORD_WIDTH-1];

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            words_d = '0;
        end else begin
            if (load_en && !empty) begin
                shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
            end
            // A new word overrides the shift; only reached when the old
            // contents are empty or on their last bit.
            if (fire) begin
                shreg_d = word_if.word_data;
                cnt_d   = is_last_word ? CNT_W'(LAST_BITS) : CNT_W'(WORD_WIDTH);
                words_d = words_q + WCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/config_loader.sv
// config_loader
//   Clears a tile configuration chain, then serializes bitstream words onto
//   it and raises done/enable after exactly CHAIN_LENGTH bits.
//   Ports:
//   - clock, reset     : config clock, async active-high reset
//   - start            : request clear+load (honoured in IDLE or DONE)
//   - word_if          : bitstream word stream (slave side)
//   - config_in        : serial bit to chain
//   - config_enable    : chain shifts on this edge
//   - config_nreset    : active-low chain clear
//   - enable, done     : fabric enable / load complete (DONE only)
//   - busy             : CLEAR or LOAD
//   - dbg_state        : current FSM state
module config_loader
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = TILE_CHAIN_LENGTH,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    config_loader_if.slave word_if,
    output logic           config_in,
    output logic           config_enable,
    output logic           config_nreset,
    output logic           enable,
    output logic           busy,
    output logic           done,
    output state_t         dbg_state
);

    localparam int BITS_W = $clog2(CHAIN_LENGTH + 1);

    state_t            state_q, state_d;
    logic [3:0]        clr_cnt_q, clr_cnt_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              nreset_q, nreset_d;
    logic              shift_valid;
    logic              shift_bit;

    config_serializer #(
        .WORD_WIDTH   (WORD_WIDTH),
        .CHAIN_LENGTH (CHAIN_LENGTH)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .clear       (state_q == ST_CLEAR),
        .load_en     (state_q == ST_LOAD),
        .word_if     (word_if),
        .shift_valid (shift_valid),
        .shift_bit   (shift_bit)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bits_d    = bits_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                bits_d = '0;
                if (clr_cnt_q == 4'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            ST_LOAD: begin
                if (shift_valid) begin
                    bits_d = bits_q + BITS_W'(1);
                    if (bits_q == BITS_W'(CHAIN_LENGTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so the chain sees nreset low during reset and for
        // exactly the cycles spent in CLEAR.
        nreset_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            bits_q    <= '0;
            nreset_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            bits_q    <= bits_d;
            nreset_q  <= nreset_d;
        end
    end

    assign config_enable = (state_q == ST_LOAD) && shift_valid;
    assign config_in     = config_enable && shift_bit;
    assign config_nreset = nreset_q;
    assign busy          = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign done          = (state_q == ST_DONE);
    assign enable        = (state_q == ST_DONE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;
    import kfpga_config_pkg::*;

    localparam int WW = 32;
    localparam int CL = 146;

    // ---------------- clock / reset ----------------
    logic   clock = 1'b0;
    logic   reset = 1'b1;
    logic   start = 1'b0;
    logic   config_in, config_enable, config_nreset, enable, busy, done;
    state_t dbg_state;

    always #5 clock = ~clock;

    config_loader_if #(.WORD_WIDTH(WW)) wif();

    config_loader #(
        .WORD_WIDTH   (WW),
        .CHAIN_LENGTH (CL),
        .CLEAR_CYCLES (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .word_if       (wif),
        .config_in     (config_in),
        .config_enable (config_enable),
        .config_nreset (config_nreset),
        .enable        (enable),
        .busy          (busy),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- chain model / monitor ----------------
    // Sampled mid-cycle: the values seen here are what the next rising
    // edge clocks into the chain. First bit shifted ends at index CL-1.
    logic [CL-1:0]   chain = '0;
    logic [WW-1:0]   words [6];
    int en_count, nlow_count, stall_count, bad_in_count, run_len, max_run;

    always @(negedge clock) begin
        if (!config_nreset) begin
            chain = '0;
            nlow_count++;
        end else if (config_enable) begin
            chain = {chain[CL-2:0], config_in};
        end
        if (config_enable) begin
            en_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (!config_enable && config_in) bad_in_count++;
        if (busy && config_nreset && !config_enable) stall_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counters();
        en_count = 0; nlow_count = 0; stall_count = 0;
        bad_in_count = 0; run_len = 0; max_run = 0;
    endtask

    task automatic set_words(input logic [WW-1:0] w, input logic [WW-1:0] last_w);
        for (int i = 0; i < 4; i++) words[i] = w;
        words[4] = last_w;
        words[5] = 32'h1234_5678;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the start edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Feeds words until done (or abort / cycle budget). cyc counts edges
    // since the start edge. valid_mode 1 withholds word_valid on every
    // third cycle so the buffer runs dry at some word boundaries.
    task automatic drive_load(input int valid_mode, input int n_offer, input int mid_start,
                              input int abort_bits, output int done_cyc, output int accepted,
                              output int first_en);
        int  idx;
        int  cyc;
        bit  hs;
        idx = 0; cyc = 0; done_cyc = -1; accepted = 0; first_en = -1;
        while (cyc < 500) begin
            if (abort_bits > 0 && en_count >= abort_bits) break;
            if (config_enable && first_en < 0) first_en = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == mid_start);
            wif.word_valid = (idx < n_offer) && (valid_mode == 0 || (cyc % 3) != 0);
            wif.word_data  = (idx < n_offer) ? words[idx] : '0;
            @(negedge clock);
            hs = wif.word_valid && wif.word_ready;
            @(posedge clock); #1;
            if (hs) begin
                idx++;
                accepted++;
            end
            cyc++;
        end
        start = 1'b0;
        wif.word_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        wif.word_valid = 1'b0; wif.word_data = '0;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (config_nreset !== 1'b0) begin fails++; $display("FAIL rst_nreset: got %b expected 0", config_nreset); end
        tests++; if ({config_enable, config_in, enable, busy, done} !== 5'b0) begin fails++; $display("FAIL rst_outputs: got %b expected 00000", {config_enable, config_in, enable, busy, done}); end
        tests++; if (wif.word_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", wif.word_ready); end
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset = 1'b0;
        wif.word_valid = 1'b1; wif.word_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (config_nreset !== 1'b0) begin fails++; $display("FAIL nreset_before_edge: got %b expected 0", config_nreset); end
        @(posedge clock); #1;
        tests++; if (config_nreset !== 1'b1) begin fails++; $display("FAIL nreset_after_edge: got %b expected 1", config_nreset); end
        @(negedge clock);
        tests++; if (wif.word_ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b expected 0", wif.word_ready); end
        @(posedge clock); #1;
        wif.word_valid = 1'b0;
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL idle_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_all_ones();
        int done_cyc, acc, first_en;
        set_words(32'hFFFF_FFFF, 32'hFFFF_C000);
        clear_counters();
        pulse_start();
        drive_load(0, 5, -1, 0, done_cyc, acc, first_en);
        tests++; if (first_en !== 3) begin fails++; $display("FAIL ones_first_enable: got %0d expected 3", first_en); end
        tests++; if (done_cyc !== 149) begin fails++; $display("FAIL ones_done_latency: got %0d expected 149", done_cyc); end
        tests++; if (en_count !== 146) begin fails++; $display("FAIL ones_enable_count: got %0d expected 146", en_count); end
        tests++; if (max_run !== 146) begin fails++; $display("FAIL ones_enable_run: got %0d expected 146", max_run); end
        tests++; if (chain !== {CL{1'b1}}) begin fails++; $display("FAIL ones_chain: got %h expected %h", chain, {CL{1'b1}}); end
        tests++; if (acc !== 5) begin fails++; $display("FAIL ones_accepted: got %0d expected 5", acc); end
        tests++; if (nlow_count !== 2) begin fails++; $display("FAIL ones_clear_cycles: got %0d expected 2", nlow_count); end
        tests++; if (stall_count !== 1) begin fails++; $display("FAIL ones_stalls: got %0d expected 1", stall_count); end
        tests++; if ({done, enable, busy, config_nreset} !== 4'b1101) begin fails++; $display("FAIL ones_done_flags: got %b expected 1101", {done, enable, busy, config_nreset}); end
    endtask

    task automatic test_alternating();
        int done_cyc, acc, first_en;
        set_words(32'hAAAA_AAAA, 32'hAAAA_AAAA);
        clear_counters();
        pulse_start();
        drive_load(1, 5, -1, 0, done_cyc, acc, first_en);
        // Dry buffer at LOAD entry (cycle 2) and before words 2, 3, 4
        // (cycles 67, 100, 133) -> done at edge 152.
        tests++; if (stall_count !== 4) begin fails++; $display("FAIL alt_stalls: got %0d expected 4", stall_count); end
        tests++; if (done_cyc !== 152) begin fails++; $display("FAIL alt_done_latency: got %0d expected 152", done_cyc); end
        tests++; if (en_count !== 146) begin fails++; $display("FAIL alt_enable_count: got %0d expected 146", en_count); end
        tests++; if (bad_in_count !== 0) begin fails++; $display("FAIL alt_idle_config_in: got %0d expected 0", bad_in_count); end
        tests++; if (chain !== {73{2'b10}}) begin fails++; $display("FAIL alt_chain: got %h expected %h", chain, {73{2'b10}}); end
        tests++; if (acc !== 5) begin fails++; $display("FAIL alt_accepted: got %0d expected 5", acc); end
    endtask

    task automatic test_start_during_load();
        int done_cyc, acc, first_en;
        set_words(32'hFFFF_FFFF, 32'hFFFF_C000);
        clear_counters();
        pulse_start();
        drive_load(0, 5, 40, 0, done_cyc, acc, first_en);
        tests++; if (done_cyc !== 149) begin fails++; $display("FAIL midstart_done_latency: got %0d expected 149", done_cyc); end
        tests++; if (nlow_count !== 2) begin fails++; $display("FAIL midstart_clear_cycles: got %0d expected 2", nlow_count); end
        tests++; if (en_count !== 146) begin fails++; $display("FAIL midstart_enable_count: got %0d expected 146", en_count); end
        tests++; if (chain !== {CL{1'b1}}) begin fails++; $display("FAIL midstart_chain: got %h expected %h", chain, {CL{1'b1}}); end
    endtask

    task automatic test_last_word();
        int done_cyc, acc, first_en;
        logic [CL-1:0] exp_chain;
        // Last word contributes its bits [31:14] = 14 zeros then 4 ones;
        // bits [13:0] are dropped.
        exp_chain = {{128{1'b1}}, 14'b0, 4'b1111};
        set_words(32'hFFFF_FFFF, 32'h0003_FFFF);
        clear_counters();
        pulse_start();
        drive_load(0, 6, -1, 0, done_cyc, acc, first_en);
        tests++; if (acc !== 5) begin fails++; $display("FAIL last_sixth_word_accepted: got %0d expected 5", acc); end
        tests++; if (chain !== exp_chain) begin fails++; $display("FAIL last_chain: got %h expected %h", chain, exp_chain); end
        tests++; if (en_count !== 146) begin fails++; $display("FAIL last_enable_count: got %0d expected 146", en_count); end
        tests++; if (done_cyc !== 149) begin fails++; $display("FAIL last_done_latency: got %0d expected 149", done_cyc); end
        wif.word_valid = 1'b1; wif.word_data = words[5];
        @(negedge clock);
        tests++; if (wif.word_ready !== 1'b0) begin fails++; $display("FAIL done_ready: got %b expected 0", wif.word_ready); end
        @(posedge clock); #1;
        wif.word_valid = 1'b0;
    endtask

    task automatic test_done_restart();
        int done_cyc, acc, first_en;
        set_words(32'hFFFF_FFFF, 32'hFFFF_C000);
        clear_counters();
        pulse_start();
        tests++; if ({done, enable, busy, config_nreset} !== 4'b0010) begin fails++; $display("FAIL restart_flags: got %b expected 0010", {done, enable, busy, config_nreset}); end
        tests++; if (dbg_state !== ST_CLEAR) begin fails++; $display("FAIL restart_state: got %0d expected %0d", dbg_state, ST_CLEAR); end
        drive_load(0, 5, -1, 0, done_cyc, acc, first_en);
        tests++; if (nlow_count !== 2) begin fails++; $display("FAIL restart_clear_cycles: got %0d expected 2", nlow_count); end
        tests++; if (done_cyc !== 149) begin fails++; $display("FAIL restart_done_latency: got %0d expected 149", done_cyc); end
        tests++; if (chain !== {CL{1'b1}}) begin fails++; $display("FAIL restart_chain: got %h expected %h", chain, {CL{1'b1}}); end
    endtask

    task automatic test_reset_abort();
        int done_cyc, acc, first_en;
        set_words(32'hFFFF_FFFF, 32'hFFFF_C000);
        clear_counters();
        pulse_start();
        drive_load(0, 5, -1, 70, done_cyc, acc, first_en);
        tests++; if (en_count !== 70) begin fails++; $display("FAIL abort_point: got %0d expected 70", en_count); end
        reset = 1'b1;
        #1;
        tests++; if ({config_enable, config_in, config_nreset, enable, busy, done} !== 6'b0) begin fails++; $display("FAIL abort_outputs: got %b expected 000000", {config_enable, config_in, config_nreset, enable, busy, done}); end
        tests++; if (wif.word_ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b expected 0", wif.word_ready); end
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        tests++; if (chain !== {CL{1'b0}}) begin fails++; $display("FAIL abort_chain_cleared: got %h expected 0", chain); end
        clear_counters();
        pulse_start();
        drive_load(0, 5, -1, 0, done_cyc, acc, first_en);
        tests++; if (nlow_count !== 2) begin fails++; $display("FAIL reload_clear_cycles: got %0d expected 2", nlow_count); end
        tests++; if (acc !== 5) begin fails++; $display("FAIL reload_accepted: got %0d expected 5", acc); end
        tests++; if (en_count !== 146) begin fails++; $display("FAIL reload_enable_count: got %0d expected 146", en_count); end
        tests++; if (done_cyc !== 149) begin fails++; $display("FAIL reload_done_latency: got %0d expected 149", done_cyc); end
        tests++; if (chain !== {CL{1'b1}}) begin fails++; $display("FAIL reload_chain: got %h expected %h", chain, {CL{1'b1}}); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        clear_counters();
        test_reset();
        test_all_ones();
        test_alternating();
        test_start_during_load();
        test_last_word();
        test_done_restart();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
